// File: rtl/if_id_stage_if.sv
// IF/ID stage bus: fetch address, instruction memory port, hazard requests
// and the decoded-stage register contents, plus debug counters and FSM state.
//
// Handshake semantics: there is no ready/valid pair on this bus. The hazard
// unit asks for a stall with data_hazard and for a redirect with
// control_hazard (redirect wins). id_valid qualifies id_pc/id_pc4/id_inst:
// a consumer takes the ID contents as a real instruction only in a cycle
// where id_valid=1. With id_valid=0 the ID contents are a bubble. They
// still hold a fixed, known value, but consumers must not use them.
interface if_id_stage_if;
  logic [31:0] pc_if;
  logic [31:0] imem_rdata;
  logic        data_hazard;
  logic        control_hazard;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
  logic        id_valid;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [1:0]  state;

  // Environment side: PC generator, instruction memory and hazard unit.
  modport master (
    output pc_if, imem_rdata, data_hazard, control_hazard,
    input  imem_addr, imem_en, id_pc, id_pc4, id_inst, id_valid,
           stall_cnt, flush_cnt, state
  );

  // Stage side.
  modport slave (
    input  pc_if, imem_rdata, data_hazard, control_hazard,
    output imem_addr, imem_en, id_pc, id_pc4, id_inst, id_valid,
           stall_cnt, flush_cnt, state
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage with a synchronous instruction memory.
// pc_q tracks the address whose data arrives on imem_rdata this cycle. During
// a stall, the stage re-reads pc_q so that the word is still available when
// the stall is released. A redirect marks the in-flight fetch as invalid
// (REFILL), which gives two bubbles before the target instruction reaches ID.
module if_id_stage (
  input  logic         clk,
  input  logic         rst,
  if_id_stage_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    REFILL = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic        pc_q_valid;
  logic        stall_cycle;
  logic        replay;
  logic [31:0] id_pc_q;
  logic [31:0] id_inst_q;
  logic        id_valid_q;
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // A stall cycle is a data hazard that is not overridden by a redirect.
  // Replay re-reads pc_q. It applies only while the in-flight fetch is
  // valid, because in REFILL the fetched address follows pc_if instead.
  assign stall_cycle = bus.data_hazard & ~bus.control_hazard;
  assign replay      = stall_cycle & (state_q != REFILL) & ~rst;

  // State register: reset parks the stage in REFILL (nothing in flight).
  always_ff @(posedge clk) begin
    if (rst) state_q <= REFILL;
    else     state_q <= state_d;
  end

  // Next state: a redirect is checked first, then the data hazard.
  always_comb begin
    state_d = state_q;
    if (bus.control_hazard) begin
      state_d = REFILL;
    end else begin
      case (state_q)
        RUN:     state_d = bus.data_hazard ? STALL  : RUN;
        STALL:   state_d = bus.data_hazard ? STALL  : RUN;
        REFILL:  state_d = bus.data_hazard ? REFILL : RUN;
        default: state_d = REFILL;
      endcase
    end
  end

  // FSM outputs: validity of the in-flight fetch and the memory port.
  always_comb begin
    pc_q_valid    = (state_q != REFILL);
    bus.imem_en   = ~rst;
    bus.imem_addr = replay ? pc_q : bus.pc_if;
  end

  // In-flight fetch address: it holds only while a valid fetch is replayed.
  always_ff @(posedge clk) begin
    if (rst)          pc_q <= 32'd0;
    else if (!replay) pc_q <= bus.pc_if;
  end

  // ID register: a redirect kills the ID contents, a stall freezes them,
  // and otherwise the ID register takes the in-flight fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_q    <= 32'd0;
      id_inst_q  <= 32'd0;
      id_valid_q <= 1'b0;
    end else if (bus.control_hazard) begin
      id_valid_q <= 1'b0;
    end else if (!bus.data_hazard) begin
      id_pc_q    <= pc_q;
      id_inst_q  <= bus.imem_rdata;
      id_valid_q <= pc_q_valid;
    end
  end

  // Saturating event counters. A cycle with both hazards counts as a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall_cycle && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (bus.control_hazard && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign bus.id_pc     = id_pc_q;
  assign bus.id_pc4    = id_pc_q + 32'd4;
  assign bus.id_inst   = id_inst_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios, random traffic,
// and counter saturation, with a one-slot fetch model feeding a scoreboard.
module tb_if_id_stage;

  localparam int W = 129;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  bit   running = 1'b0;
  logic [W-1:0] exp_q[$];

  if_id_stage_if bus ();

  if_id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and initial input values.
  always #5 clk = ~clk;

  initial begin
    rst                = 1'b1;
    bus.pc_if          = 32'd0;
    bus.data_hazard    = 1'b0;
    bus.control_hazard = 1'b0;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1000_0000;
  endfunction

  // Synchronous instruction memory: returns the word of last cycle's address.
  always @(posedge clk) bus.imem_rdata <= mem_word(bus.imem_addr);

  // Reference model. The instruction memory holds one fetch in flight
  // (address, whether it is a real instruction, and the word it returns).
  // The ID register either takes that fetch, keeps its contents, or is
  // killed.
  logic [31:0] m_slot_pc, m_slot_word, m_id_pc, m_id_inst;
  logic        m_slot_real, m_id_valid;
  int          m_stall, m_flush;

  task automatic model_step(input logic r, input logic [31:0] pc,
                            input logic dh, input logic ch);
    if (r) begin
      m_id_valid = 0; m_id_pc = 0; m_id_inst = 0;
      m_slot_pc = 0; m_slot_real = 0; m_slot_word = mem_word(pc);
      m_stall = 0; m_flush = 0;
    end else if (ch) begin
      if (m_flush < 65535) m_flush++;
      m_id_valid = 0;
      m_slot_pc = pc; m_slot_real = 0; m_slot_word = mem_word(pc);
    end else if (dh) begin
      if (m_stall < 65535) m_stall++;
      // A fetch that has already been discarded is not kept. The stage
      // tracks the newest address, and that fetch stays discarded.
      if (!m_slot_real) begin
        m_slot_pc = pc; m_slot_word = mem_word(pc);
      end
    end else begin
      m_id_valid = m_slot_real; m_id_pc = m_slot_pc; m_id_inst = m_slot_word;
      m_slot_pc = pc; m_slot_real = 1; m_slot_word = mem_word(pc);
    end
  endtask

  // Driver: applies one cycle of inputs and records the expected ID contents
  // and counter values after the coming clock edge.
  task automatic drive(input logic r, input logic [31:0] pc,
                       input logic dh, input logic ch);
    logic [31:0] p4;
    @(negedge clk);
    rst = r; bus.pc_if = pc; bus.data_hazard = dh; bus.control_hazard = ch;
    running = 1'b1;
    model_step(r, pc, dh, ch);
    p4 = m_id_pc + 32'd4;
    exp_q.push_back({m_id_valid, m_id_pc, p4, m_id_inst,
                     m_stall[15:0], m_flush[15:0]});
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: after every clock edge, pops one expected record and compares.
  always begin
    logic [W-1:0] e, g;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {bus.id_valid, bus.id_pc, bus.id_pc4, bus.id_inst,
           bus.stall_cnt, bus.flush_cnt};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL id_state t=%0t: got v=%b pc=%h pc4=%h inst=%h stall=%h flush=%h; expected v=%b pc=%h pc4=%h inst=%h stall=%h flush=%h",
                 $time, g[128], g[127:96], g[95:64], g[63:32], g[31:16], g[15:0],
                 e[128], e[127:96], e[95:64], e[63:32], e[31:16], e[15:0]);
      end
    end else if (running) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty t=%0t: got no expected record, required one", $time);
    end
  end

  // Stimulus.
  initial begin
    logic [31:0] pc;
    logic        r, dh, ch;

    // Reset.
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    after_edge();
    check("reset_id_pc", bus.id_pc, 0);
    check("reset_id_inst", bus.id_inst, 0);
    check("reset_id_valid", {31'd0, bus.id_valid}, 0);
    check("reset_state", {30'd0, bus.state}, 2);
    check("reset_imem_en", {31'd0, bus.imem_en}, 0);
    check("reset_counters", {bus.stall_cnt, bus.flush_cnt}, 0);

    // Straight-line fetch.
    drive(0, 32'h0, 0, 0);
    #1 check("run_imem_en", {31'd0, bus.imem_en}, 1);
    drive(0, 32'h4, 0, 0);
    after_edge();
    check("first_id_pc", bus.id_pc, 32'h0);
    check("first_id_inst", bus.id_inst, 32'h1000_0000);
    check("first_id_valid", {31'd0, bus.id_valid}, 1);
    drive(0, 32'h8, 0, 0);

    // Stall for three cycles with pc_q=0x8.
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'hC, 1, 0);
      #1 check("stall_imem_addr", bus.imem_addr, 32'h8);
    end
    after_edge();
    check("stall_state", {30'd0, bus.state}, 1);
    check("stall_id_pc", bus.id_pc, 32'h4);
    check("stall_cnt3", {16'd0, bus.stall_cnt}, 3);
    drive(0, 32'hC, 0, 0);
    after_edge();
    check("release_id_pc", bus.id_pc, 32'h8);
    check("release_id_inst", bus.id_inst, 32'h1000_0008);
    check("release_state", {30'd0, bus.state}, 0);

    // One-cycle flush, then the target stream starting at 0x40.
    drive(0, 32'h10, 0, 1);
    after_edge();
    check("flush_bubble1", {31'd0, bus.id_valid}, 0);
    check("flush_state", {30'd0, bus.state}, 2);
    check("flush_hold_pc", bus.id_pc, 32'h8);
    check("flush_cnt1", {16'd0, bus.flush_cnt}, 1);
    drive(0, 32'h40, 0, 0);
    after_edge();
    check("flush_bubble2", {31'd0, bus.id_valid}, 0);
    drive(0, 32'h44, 0, 0);
    after_edge();
    check("flush_target_valid", {31'd0, bus.id_valid}, 1);
    check("flush_target_pc", bus.id_pc, 32'h40);
    drive(0, 32'h48, 0, 0);

    // Both hazards at once count only as a flush.
    drive(0, 32'h50, 1, 1);
    after_edge();
    check("both_state", {30'd0, bus.state}, 2);
    check("both_flush_cnt", {16'd0, bus.flush_cnt}, 2);
    check("both_stall_cnt", {16'd0, bus.stall_cnt}, 3);
    drive(0, 32'h80, 1, 0);
    after_edge();
    check("refill_stall_state", {30'd0, bus.state}, 2);
    drive(0, 32'h80, 0, 0);
    drive(0, 32'h84, 0, 0);
    drive(0, 32'h88, 0, 0);

    // Reset while stalled.
    drive(0, 32'h98, 1, 0);
    drive(0, 32'h98, 1, 0);
    after_edge();
    check("pre_reset_state", {30'd0, bus.state}, 1);
    drive(1, 32'h98, 1, 0);
    #1 check("mid_reset_imem_en", {31'd0, bus.imem_en}, 0);
    after_edge();
    check("mid_reset_id_pc", bus.id_pc, 0);
    check("mid_reset_id_inst", bus.id_inst, 0);
    check("mid_reset_id_valid", {31'd0, bus.id_valid}, 0);
    check("mid_reset_state", {30'd0, bus.state}, 2);
    check("mid_reset_counters", {bus.stall_cnt, bus.flush_cnt}, 0);

    // id_pc4 wraps past the top of the address space.
    drive(0, 32'hFFFF_FFF8, 0, 0);
    drive(0, 32'hFFFF_FFFC, 0, 0);
    drive(0, 32'h0, 0, 0);
    after_edge();
    check("wrap_id_pc", bus.id_pc, 32'hFFFF_FFFC);
    check("wrap_id_pc4", bus.id_pc4, 32'h0);

    // Random traffic.
    pc = 32'h4;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      ch = ($urandom_range(0, 9) == 0);
      dh = ($urandom_range(0, 3) == 0);
      if (ch) pc = $urandom() & 32'hFFFF_FFFC;
      drive(r, pc, dh, ch);
      if (!dh || ch) pc = pc + 32'd4;
    end

    // Stall counter saturation.
    for (int i = 0; i < 70000; i++) drive(0, pc, 1, 0);
    after_edge();
    check("stall_cnt_sat", {16'd0, bus.stall_cnt}, 32'hFFFF);
    drive(0, pc, 1, 0);
    after_edge();
    check("stall_cnt_no_wrap", {16'd0, bus.stall_cnt}, 32'hFFFF);
    drive(0, pc, 0, 0);
    after_edge();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
